hazard_stall_ctrl: RTL and testbench

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_stall_ctrl_pkg.sv | 26 ++
 rtl/hazard_stall_ctrl_match.sv | 47 ++++
 rtl/hazard_stall_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants for the decode-stage hazard/stall controller:
// RV32 opcodes, default pipeline latencies, stall width and FSM states.
package hazard_stall_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;

    localparam int LAT_ALU_BR_DEF = 1;
    localparam int LAT_LD_ANY_DEF = 1;
    localparam int LAT_LD_BR_DEF  = 2;

    // Width of a per-instruction stall length (latencies up to 15 cycles).
    localparam int STALL_W = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_stall_ctrl_match.sv
// Combinational per-entry hazard check: given the consumer's sources and one
// producer-history entry at distance D, returns the stall cycles that entry
// demands (zero when there is no dependency or the latency is already covered).
module hazard_match
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_LOGSIZE = 5,
    parameter int LAT_ALU_BR  = LAT_ALU_BR_DEF,
    parameter int LAT_LD_ANY  = LAT_LD_ANY_DEF,
    parameter int LAT_LD_BR   = LAT_LD_BR_DEF,
    parameter int D           = 1
) (
    input  logic [REG_LOGSIZE-1:0] rs1,
    input  logic [REG_LOGSIZE-1:0] rs2,
    input  logic                   is_branch,
    input  logic                   ent_valid,
    input  logic [REG_LOGSIZE-1:0] ent_rd,
    input  logic                   ent_is_load,
    output logic [STALL_W-1:0]     stall
);

    localparam logic [REG_LOGSIZE-1:0] REG_ZERO = {REG_LOGSIZE{1'b0}};

    logic [STALL_W-1:0] lat_s;
    logic               match_s;

    // Latency for this producer/consumer pair and the remaining stall at distance D.
    always_comb begin
        lat_s   = {STALL_W{1'b0}};
        match_s = 1'b0;
        stall   = {STALL_W{1'b0}};
        if (ent_is_load) begin
            lat_s = is_branch ? STALL_W'(LAT_LD_BR) : STALL_W'(LAT_LD_ANY);
        end else begin
            lat_s = is_branch ? STALL_W'(LAT_ALU_BR) : {STALL_W{1'b0}};
        end
        match_s = ent_valid && (ent_rd != REG_ZERO) &&
                  (((rs1 != REG_ZERO) && (rs1 == ent_rd)) ||
                   ((rs2 != REG_ZERO) && (rs2 == ent_rd)));
        if (match_s && (lat_s >= STALL_W'(D))) begin
            stall = lat_s - STALL_W'(D) + STALL_W'(1);
        end else begin
            stall = {STALL_W{1'b0}};
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard/stall controller. Tracks the last DEPTH issued
// producers, computes the stall the decode instruction needs, and drives
// PC/F-D enables and bubble insertion, with flush and global-freeze handling.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int REG_LOGSIZE = 5,
    parameter int LAT_ALU_BR  = LAT_ALU_BR_DEF,
    parameter int LAT_LD_ANY  = LAT_LD_ANY_DEF,
    parameter int LAT_LD_BR   = LAT_LD_BR_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      instr_in,
    input  logic             ext_stall,
    input  logic             flush,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_bubble,
    output logic             fd_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [REG_LOGSIZE-1:0] REG_ZERO = {REG_LOGSIZE{1'b0}};

    logic [6:0]             opcode_s;
    logic [REG_LOGSIZE-1:0] rs1_s, rs2_s, rd_s;
    logic                   is_load_s, is_branch_s, issue_s, hazard_cycle_s;
    logic                   unused_s;

    logic                   hist_valid_r [1:DEPTH];
    logic [REG_LOGSIZE-1:0] hist_rd_r    [1:DEPTH];
    logic                   hist_load_r  [1:DEPTH];
    logic [STALL_W-1:0]     ent_stall_s  [1:DEPTH];
    logic [STALL_W-1:0]     req_stall_s;

    state_t                 state_r, state_nx;
    logic [STALL_W-1:0]     cnt_r, cnt_nx;
    logic [CNT_W-1:0]       stall_count_r;

    assign unused_s    = ^{instr_in[31:25], instr_in[14:12]};
    assign stall_count = stall_count_r;
    assign issue_s     = instr_valid & fd_en & ~flush & ~ext_stall;

    // Register-field decode; formats without a given field read as x0.
    always_comb begin
        opcode_s    = instr_in[6:0];
        is_load_s   = (opcode_s == OP_LOAD);
        is_branch_s = (opcode_s == OP_BRANCH);
        if ((opcode_s == OP_JAL) || (opcode_s == OP_LUI) || (opcode_s == OP_AUIPC)) begin
            rs1_s = REG_ZERO;
        end else begin
            rs1_s = REG_LOGSIZE'(instr_in[19:15]);
        end
        if ((opcode_s == OP_JAL) || (opcode_s == OP_LUI) || (opcode_s == OP_AUIPC) ||
            (opcode_s == OP_LOAD) || (opcode_s == OP_ITYPE)) begin
            rs2_s = REG_ZERO;
        end else begin
            rs2_s = REG_LOGSIZE'(instr_in[24:20]);
        end
        if ((opcode_s == OP_STORE) || (opcode_s == OP_BRANCH)) begin
            rd_s = REG_ZERO;
        end else begin
            rd_s = REG_LOGSIZE'(instr_in[11:7]);
        end
    end

    for (genvar g = 1; g <= DEPTH; g++) begin : g_match
        hazard_match #(
            .REG_LOGSIZE (REG_LOGSIZE),
            .LAT_ALU_BR  (LAT_ALU_BR),
            .LAT_LD_ANY  (LAT_LD_ANY),
            .LAT_LD_BR   (LAT_LD_BR),
            .D           (g)
        ) u_match (
            .rs1         (rs1_s),
            .rs2         (rs2_s),
            .is_branch   (is_branch_s),
            .ent_valid   (hist_valid_r[g]),
            .ent_rd      (hist_rd_r[g]),
            .ent_is_load (hist_load_r[g]),
            .stall       (ent_stall_s[g])
        );
    end

    // Worst-case stall over all history entries.
    always_comb begin
        req_stall_s = {STALL_W{1'b0}};
        for (int i = 1; i <= DEPTH; i++) begin
            if (ent_stall_s[i] > req_stall_s) begin
                req_stall_s = ent_stall_s[i];
            end else begin
                req_stall_s = req_stall_s;
            end
        end
    end

    // Producer history: shift on every unfrozen cycle, issuing or inserting a hole.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= DEPTH; i++) begin
                hist_valid_r[i] <= 1'b0;
                hist_rd_r[i]    <= REG_ZERO;
                hist_load_r[i]  <= 1'b0;
            end
        end else if (!ext_stall) begin
            hist_valid_r[1] <= issue_s;
            hist_rd_r[1]    <= issue_s ? rd_s : REG_ZERO;
            hist_load_r[1]  <= issue_s & is_load_s;
            for (int i = 2; i <= DEPTH; i++) begin
                hist_valid_r[i] <= hist_valid_r[i-1];
                hist_rd_r[i]    <= hist_rd_r[i-1];
                hist_load_r[i]  <= hist_load_r[i-1];
            end
        end else begin
            for (int i = 1; i <= DEPTH; i++) begin
                hist_valid_r[i] <= hist_valid_r[i];
                hist_rd_r[i]    <= hist_rd_r[i];
                hist_load_r[i]  <= hist_load_r[i];
            end
        end
    end

    // Next-state and output decode. The RUN cycle that detects a hazard is
    // itself the first stall cycle, so cnt holds the stall cycles still owed
    // after the current one and STALL is only entered when more than one is needed.
    always_comb begin
        state_nx       = state_r;
        cnt_nx         = cnt_r;
        pc_en          = 1'b1;
        fd_en          = 1'b1;
        de_bubble      = 1'b0;
        fd_bubble      = 1'b0;
        busy           = 1'b0;
        hazard_cycle_s = 1'b0;
        if (rst) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_bubble = 1'b1;
            fd_bubble = 1'b1;
            state_nx  = ST_RUN;
            cnt_nx    = {STALL_W{1'b0}};
        end else if (ext_stall) begin
            pc_en = 1'b0;
            fd_en = 1'b0;
            busy  = (state_r == ST_STALL);
        end else if (flush) begin
            de_bubble = 1'b1;
            fd_bubble = 1'b1;
            cnt_nx    = {STALL_W{1'b0}};
            state_nx  = ST_FLUSH;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (instr_valid && (req_stall_s != {STALL_W{1'b0}})) begin
                        pc_en          = 1'b0;
                        fd_en          = 1'b0;
                        de_bubble      = 1'b1;
                        busy           = 1'b1;
                        hazard_cycle_s = 1'b1;
                        if (req_stall_s > STALL_W'(1)) begin
                            state_nx = ST_STALL;
                            cnt_nx   = req_stall_s - STALL_W'(1);
                        end else begin
                            state_nx = ST_RUN;
                            cnt_nx   = {STALL_W{1'b0}};
                        end
                    end else begin
                        state_nx = ST_RUN;
                    end
                end
                ST_STALL: begin
                    pc_en          = 1'b0;
                    fd_en          = 1'b0;
                    de_bubble      = 1'b1;
                    busy           = 1'b1;
                    hazard_cycle_s = 1'b1;
                    if (cnt_r <= STALL_W'(1)) begin
                        state_nx = ST_RUN;
                        cnt_nx   = {STALL_W{1'b0}};
                    end else begin
                        cnt_nx = cnt_r - STALL_W'(1);
                    end
                end
                ST_FLUSH: begin
                    state_nx = ST_RUN;
                end
                default: begin
                    state_nx = ST_RUN;
                    cnt_nx   = {STALL_W{1'b0}};
                end
            endcase
        end
    end

    // State, down-counter and saturating hazard-stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            cnt_r         <= {STALL_W{1'b0}};
            stall_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            if (hazard_cycle_s && (stall_count_r != {CNT_W{1'b1}})) begin
                stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl. A reference model re-derives the
// required stall every cycle from the producer history (no counter), and
// directed scenarios add hand-computed literal expectations.
module tb_hazard_stall_ctrl;

    localparam int DEPTH = 2;
    localparam int CW    = 4;
    localparam int CMAX  = 15;

    localparam logic [31:0] NOP      = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] LW5      = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] ADD6_5_7 = 32'h0072_8333; // add  x6,x5,x7
    localparam logic [31:0] BEQ5     = 32'h0002_8063; // beq  x5,x0
    localparam logic [31:0] ADD0_1_2 = 32'h0020_8033; // add  x0,x1,x2
    localparam logic [31:0] BEQ00    = 32'h0000_0063; // beq  x0,x0
    localparam logic [31:0] ADDI7    = 32'h0010_0393; // addi x7,x0,1
    localparam logic [31:0] BEQ7     = 32'h0003_8063; // beq  x7,x0

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_valid = 1'b0;
    logic [31:0]   instr_in = NOP;
    logic          ext_stall = 1'b0;
    logic          flush = 1'b0;
    logic          pc_en, fd_en, de_bubble, fd_bubble, busy;
    logic [CW-1:0] stall_count;

    int checks   = 0;
    int failures = 0;

    hazard_stall_ctrl #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_in(instr_in),
        .ext_stall(ext_stall), .flush(flush), .pc_en(pc_en), .fd_en(fd_en),
        .de_bubble(de_bubble), .fd_bubble(fd_bubble), .busy(busy),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_v [1:DEPTH];
    int m_rd[1:DEPTH];
    int m_ld[1:DEPTH];
    bit m_after_flush = 1'b0;
    bit m_cont = 1'b0;
    int m_count = 0;

    function automatic int f_rd(input logic [31:0] ins);
        if (ins[6:0] == 7'b0100011 || ins[6:0] == 7'b1100011) return 0;
        return int'(ins[11:7]);
    endfunction

    function automatic int calc_s(input logic [31:0] ins);
        logic [6:0] op;
        int rs1, rs2, s, lat;
        bit br;
        op  = ins[6:0];
        rs1 = int'(ins[19:15]);
        rs2 = int'(ins[24:20]);
        if (op == 7'b1101111 || op == 7'b0110111 || op == 7'b0010111) rs1 = 0;
        if (op == 7'b1101111 || op == 7'b0110111 || op == 7'b0010111 ||
            op == 7'b0000011 || op == 7'b0010011) rs2 = 0;
        br = (op == 7'b1100011);
        s  = 0;
        for (int d = 1; d <= DEPTH; d++) begin
            if (m_v[d] != 0 && m_rd[d] != 0 &&
                ((rs1 != 0 && rs1 == m_rd[d]) || (rs2 != 0 && rs2 == m_rd[d]))) begin
                if (m_ld[d] != 0) lat = br ? 2 : 1;
                else              lat = br ? 1 : 0;
                if (lat - d + 1 > s) s = lat - d + 1;
            end
        end
        return s;
    endfunction

    task automatic push(input int v, input int rd, input int ld);
        for (int i = DEPTH; i >= 2; i--) begin
            m_v[i] = m_v[i-1]; m_rd[i] = m_rd[i-1]; m_ld[i] = m_ld[i-1];
        end
        m_v[1] = v; m_rd[1] = rd; m_ld[1] = ld;
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        int e_pc, e_fd, e_deb, e_fdb, e_busy, s;
        s = 0;
        if (rst) begin
            e_pc = 0; e_fd = 0; e_deb = 1; e_fdb = 1; e_busy = 0;
        end else if (ext_stall) begin
            e_pc = 0; e_fd = 0; e_deb = 0; e_fdb = 0; e_busy = int'(m_cont);
        end else if (flush) begin
            e_pc = 1; e_fd = 1; e_deb = 1; e_fdb = 1; e_busy = 0;
        end else if (m_after_flush) begin
            e_pc = 1; e_fd = 1; e_deb = 0; e_fdb = 0; e_busy = 0;
        end else begin
            s = instr_valid ? calc_s(instr_in) : 0;
            if (s > 0) begin
                e_pc = 0; e_fd = 0; e_deb = 1; e_fdb = 0; e_busy = 1;
            end else begin
                e_pc = 1; e_fd = 1; e_deb = 0; e_fdb = 0; e_busy = 0;
            end
        end
        chk("m_pc_en",       int'(pc_en),       e_pc);
        chk("m_fd_en",       int'(fd_en),       e_fd);
        chk("m_de_bubble",   int'(de_bubble),   e_deb);
        chk("m_fd_bubble",   int'(fd_bubble),   e_fdb);
        chk("m_busy",        int'(busy),        e_busy);
        chk("m_stall_count", int'(stall_count), m_count);
        if (rst) begin
            for (int i = 1; i <= DEPTH; i++) begin
                m_v[i] = 0; m_rd[i] = 0; m_ld[i] = 0;
            end
            m_after_flush = 1'b0; m_cont = 1'b0; m_count = 0;
        end else if (ext_stall) begin
            m_count = m_count;
        end else if (flush) begin
            push(0, 0, 0); m_after_flush = 1'b1; m_cont = 1'b0;
        end else if (m_after_flush) begin
            if (instr_valid) push(1, f_rd(instr_in), int'(instr_in[6:0] == 7'b0000011));
            else             push(0, 0, 0);
            m_after_flush = 1'b0; m_cont = 1'b0;
        end else if (s > 0) begin
            push(0, 0, 0);
            m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
            m_cont  = (s > 1);
        end else begin
            if (instr_valid) push(1, f_rd(instr_in), int'(instr_in[6:0] == 7'b0000011));
            else             push(0, 0, 0);
            m_cont = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit r, input bit v, input logic [31:0] ins,
                       input bit es, input bit fl);
        @(posedge clk);
        #1;
        rst = r; instr_valid = v; instr_in = ins; ext_stall = es; flush = fl;
        #1;
    endtask

    task automatic run(input logic [31:0] ins);
        cyc(1'b0, 1'b1, ins, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 1; i <= DEPTH; i++) begin
            m_v[i] = 0; m_rd[i] = 0; m_ld[i] = 0;
        end
        cyc(1'b1, 1'b0, NOP, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, NOP, 1'b0, 1'b0);
        chk("rst_pc_en", int'(pc_en), 0);
        chk("rst_fd_bubble", int'(fd_bubble), 1);
        chk("rst_de_bubble", int'(de_bubble), 1);
        chk("rst_busy", int'(busy), 0);
        run(NOP);
        chk("run_pc_en", int'(pc_en), 1);
        chk("rst_stall_count", int'(stall_count), 0);

        // load then dependent ALU op: one stall cycle
        run(LW5);
        run(ADD6_5_7);
        chk("ld_alu_pc_en", int'(pc_en), 0);
        chk("ld_alu_de_bubble", int'(de_bubble), 1);
        chk("ld_alu_busy", int'(busy), 1);
        run(ADD6_5_7);
        chk("ld_alu_release", int'(pc_en), 1);
        chk("ld_alu_count", int'(stall_count), 1);
        run(NOP); run(NOP);

        // load then dependent branch at distance 1: two stall cycles
        run(LW5);
        run(BEQ5);
        chk("ld_br_c1", int'(pc_en), 0);
        run(BEQ5);
        chk("ld_br_c2", int'(pc_en), 0);
        chk("ld_br_c2_busy", int'(busy), 1);
        run(BEQ5);
        chk("ld_br_release", int'(pc_en), 1);
        chk("ld_br_count", int'(stall_count), 3);
        run(NOP); run(NOP);

        // load, nop, branch: one stall cycle
        run(LW5); run(NOP);
        run(BEQ5);
        chk("ld_nop_br_c1", int'(pc_en), 0);
        run(BEQ5);
        chk("ld_nop_br_release", int'(pc_en), 1);
        chk("ld_nop_br_count", int'(stall_count), 4);

        // x0 destination never creates a hazard
        run(ADD0_1_2);
        run(BEQ00);
        chk("x0_pc_en", int'(pc_en), 1);
        chk("x0_busy", int'(busy), 0);

        // ALU then dependent branch: one stall cycle
        run(ADDI7);
        run(BEQ7);
        chk("alu_br_c1", int'(de_bubble), 1);
        run(BEQ7);
        chk("alu_br_release", int'(pc_en), 1);
        chk("alu_br_count", int'(stall_count), 5);
        run(NOP); run(NOP);

        // flush during the first STALL cycle of a load/branch hazard
        run(LW5);
        run(BEQ5);
        cyc(1'b0, 1'b1, BEQ5, 1'b0, 1'b1);
        chk("flush_fd_bubble", int'(fd_bubble), 1);
        chk("flush_de_bubble", int'(de_bubble), 1);
        chk("flush_busy", int'(busy), 0);
        cyc(1'b0, 1'b0, NOP, 1'b0, 1'b0);
        chk("flushst_pc_en", int'(pc_en), 1);
        chk("flushst_de_bubble", int'(de_bubble), 0);
        run(BEQ5);
        chk("after_flush_pc_en", int'(pc_en), 1);
        chk("after_flush_count", int'(stall_count), 6);
        run(NOP); run(NOP);

        // ext_stall held 3 cycles mid-STALL, one with flush that must be ignored
        run(LW5);
        run(BEQ5);
        cyc(1'b0, 1'b1, BEQ5, 1'b1, 1'b0);
        chk("frz_pc_en", int'(pc_en), 0);
        chk("frz_de_bubble", int'(de_bubble), 0);
        cyc(1'b0, 1'b1, BEQ5, 1'b1, 1'b1);
        chk("frz_flush_ignored", int'(fd_bubble), 0);
        cyc(1'b0, 1'b1, BEQ5, 1'b1, 1'b0);
        chk("frz_count_hold", int'(stall_count), 7);
        run(BEQ5);
        chk("frz_resume_stall", int'(de_bubble), 1);
        run(BEQ5);
        chk("frz_release", int'(pc_en), 1);
        chk("frz_count", int'(stall_count), 8);
        run(NOP); run(NOP);

        // reset in the middle of a STALL
        run(LW5);
        run(BEQ5);
        cyc(1'b1, 1'b1, BEQ5, 1'b0, 1'b0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_fd_bubble", int'(fd_bubble), 1);
        run(BEQ5);
        chk("post_rst_pc_en", int'(pc_en), 1);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_count", int'(stall_count), 0);

        // saturation: 14 hazard cycles reach all-ones-1, two more saturate
        for (int k = 0; k < 7; k++) begin
            run(LW5); run(BEQ5); run(BEQ5); run(BEQ5);
        end
        chk("sat_preload", int'(stall_count), CMAX - 1);
        run(LW5); run(BEQ5); run(BEQ5); run(BEQ5);
        chk("sat_reach", int'(stall_count), CMAX);
        run(LW5); run(BEQ5); run(BEQ5); run(BEQ5);
        chk("sat_hold", int'(stall_count), CMAX);
        run(NOP);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
